// File: rtl/ob.sv
// Output buffer: a small FIFO between one crossbar output and an egress sink.
// Overflowing packets are dropped and counted in a saturating counter.
module ob #(
  parameter int unsigned PKTW = 15,
  parameter int unsigned AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PKTW:0] din,
  output logic [PKTW:0] dout,
  output logic          dvalid,
  input  logic          drdy,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          ovf,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] CntFull = (AW+1)'(Depth);

  logic [PKTW:0] mem_q [Depth];
  logic [PKTW:0] mem_d [Depth];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  logic wr_req, wr_en, rd_en;

  assign dvalid   = (cnt_q != '0);
  assign full     = (cnt_q == CntFull);
  assign cnt      = cnt_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;
  // Stored words always carry the valid bit, so dout[PKTW] tracks dvalid.
  assign dout     = dvalid ? mem_q[rptr_q] : '0;

  assign wr_req = din[PKTW];
  assign rd_en  = dvalid && drdy;
  // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_en  = wr_req && (!full || rd_en);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;

    if (wr_en) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 1'b1;
    end
    if (rd_en) begin
      rptr_d = rptr_q + 1'b1;
    end

    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (wr_req && !wr_en) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hff) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  // Storage needs no reset: it is only visible through dout when cnt is non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_ob.sv
// Directed self-checking bench for the ob output buffer.
module tb_ob;

  localparam int unsigned PKTW = 15;
  localparam int unsigned AW   = 2;

  logic          clk;
  logic          rst;
  logic [PKTW:0] din;
  logic [PKTW:0] dout;
  logic          dvalid;
  logic          drdy;
  logic [AW:0]   cnt;
  logic          full;
  logic          ovf;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  ob #(.PKTW(PKTW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .dout     (dout),
    .dvalid   (dvalid),
    .drdy     (drdy),
    .cnt      (cnt),
    .full     (full),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_dout, input logic [31:0] e_cnt,
                           input logic e_full, input logic e_ovf, input logic [31:0] e_drop);
    chk({tag, ".dout"}, 32'(dout), e_dout);
    chk({tag, ".dvalid"}, 32'(dvalid), 32'(e_cnt != 0));
    chk({tag, ".cnt"}, 32'(cnt), e_cnt);
    chk({tag, ".full"}, 32'(full), 32'(e_full));
    chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
    chk({tag, ".drop"}, 32'(drop_cnt), e_drop);
  endtask

  initial begin
    rst  = 1'b0;
    din  = '0;
    drdy = 1'b0;
    step();
    step();
    chk_state("reset", 32'h0, 0, 1'b0, 1'b0, 0);

    // Invalid word on an empty FIFO is ignored.
    rst = 1'b1;
    din = 16'h0005;
    step();
    din = '0;
    chk_state("invalid_din", 32'h0, 0, 1'b0, 1'b0, 0);

    // Single packet: one-cycle latency, held while drdy low.
    din = 16'h8001;
    step();
    din = '0;
    chk_state("single_wr", 32'h8001, 1, 1'b0, 1'b0, 0);
    step();
    chk_state("single_hold", 32'h8001, 1, 1'b0, 1'b0, 0);
    drdy = 1'b1;
    step();
    drdy = 1'b0;
    chk_state("single_rd", 32'h0, 0, 1'b0, 1'b0, 0);
    step();
    chk_state("empty_rd", 32'h0, 0, 1'b0, 1'b0, 0);

    // Fill to full, then overflow one packet.
    for (int i = 1; i <= 4; i++) begin
      din = 16'(32'h8000 + i);
      step();
    end
    din = '0;
    chk_state("fill", 32'h8001, 4, 1'b1, 1'b0, 0);
    din = 16'h8005;
    step();
    din = '0;
    chk_state("overflow", 32'h8001, 4, 1'b1, 1'b1, 1);

    // Write and read together while full: no drop.
    din  = 16'h8009;
    drdy = 1'b1;
    step();
    din = '0;
    chk_state("full_wr_rd", 32'h8002, 4, 1'b1, 1'b1, 1);

    // Drain: remaining order 8002, 8003, 8004, 8009.
    step();
    chk("drain1", 32'(dout), 32'h8003);
    step();
    chk("drain2", 32'(dout), 32'h8004);
    step();
    chk("drain3", 32'(dout), 32'h8009);
    step();
    chk_state("drained", 32'h0, 0, 1'b0, 1'b1, 1);

    // Streaming: write every cycle with drdy high, occupancy stays at one.
    for (int i = 0; i < 20; i++) begin
      din = 16'(32'h8010 + i);
      step();
      chk("stream.dout", 32'(dout), 32'h8010 + i);
      chk("stream.cnt", 32'(cnt), 1);
    end
    din = '0;
    step();
    chk_state("stream_end", 32'h0, 0, 1'b0, 1'b1, 1);

    // 300 writes with sink stalled: 4 stored, 296 more drops saturate the counter.
    drdy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      din = 16'(32'h8100 + i);
      step();
    end
    din = '0;
    chk_state("saturate", 32'h8100, 4, 1'b1, 1'b1, 255);

    // Reset wins over a concurrent write and discards contents.
    rst = 1'b0;
    din = 16'h8777;
    step();
    rst = 1'b1;
    din = '0;
    chk_state("mid_reset", 32'h0, 0, 1'b0, 1'b0, 0);
    din = 16'h8abc;
    step();
    din = '0;
    chk_state("post_reset_wr", 32'h8abc, 1, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ob.md
OB -- requirements
Module: ob

Interface
REQ-001 Parameter PKTW, default 15, index of packet MSB; packet width PKTW+1; bit PKTW is the packet valid flag.
REQ-002 Parameter AW, default 2, FIFO address width; depth = 2^AW entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 din  input  PKTW+1  packet from one crossbar output; din[PKTW]=1 marks a packet present this cycle.
REQ-006 dout  output  PKTW+1  head-of-FIFO packet to egress sink; all-zero when empty.
REQ-007 dvalid  output  1  FIFO non-empty; dout holds a valid packet.
REQ-008 drdy  input  1  sink accepts dout this cycle.
REQ-009 cnt  output  AW+1  current occupancy, 0..2^AW.
REQ-010 full  output  1  cnt == 2^AW.
REQ-011 ovf  output  1  sticky flag; a packet was dropped since reset.
REQ-012 drop_cnt  output  8  number of dropped packets, saturating.

Function
REQ-013 Write event: din[PKTW]==1 at a rising edge; the whole din word is stored at the tail.
REQ-014 Read event: dvalid && drdy at a rising edge; head entry is removed.
REQ-015 din with din[PKTW]==0 is ignored entirely; payload bits are don't-care.
REQ-016 Write-to-dvalid latency: exactly one cycle from the write edge when FIFO was empty; no combinational din-to-dout path.
REQ-017 dout and dvalid are driven from registers/storage only; no combinational dependence on drdy.
REQ-018 While dvalid && !drdy, dout is held unchanged.
REQ-019 dout[PKTW] equals dvalid at all times; when cnt==0, dout is all-zero.
REQ-020 Ordering is strict FIFO; no packet reordered, duplicated or corrupted.
REQ-021 Simultaneous write and read with 0<cnt<2^AW: both succeed, cnt unchanged.
REQ-022 Simultaneous write and read when full: both succeed, cnt stays 2^AW, no drop.
REQ-023 Write when empty while drdy==1: packet is stored, not bypassed; cnt becomes 1.
REQ-024 Write when full without read: packet dropped, storage unchanged, ovf set, drop_cnt incremented.
REQ-025 drop_cnt saturates at 255; further drops leave it at 255; ovf stays 1.
REQ-026 Read when empty (drdy==1, dvalid==0) has no effect.
REQ-027 Read and write pointers are AW bits and wrap modulo 2^AW; occupancy tracked in AW+1-bit cnt.
REQ-028 full and dvalid are derived from cnt registered state, valid in the same cycle as cnt.

Reset
REQ-029 When rst==0 at a rising edge: cnt=0, pointers=0, dvalid=0, dout=0, full=0, ovf=0, drop_cnt=0.
REQ-030 Reset takes priority over any simultaneous write or read; the concurrent din packet is discarded.
REQ-031 Reset asserted mid-operation discards all stored packets; first write after rst returns to 1 follows REQ-016.

Verification
REQ-032 Reset, then din=0x8001 one cycle, drdy=0 -> next cycle dvalid=1, dout=0x8001, cnt=1; holds until drdy=1, then cnt=0, dout=0x0000.
REQ-033 drdy=0, write 0x8001..0x8004 back-to-back -> full=1, cnt=4; fifth write 0x8005 -> dropped, ovf=1, drop_cnt=1; drain gives 0x8001..0x8004 in order.
REQ-034 FIFO full, drdy=1 and din=0x8009 same cycle -> 0x8001 read, 0x8009 stored at tail, cnt=4, drop_cnt unchanged.
REQ-035 Continuous writes and drdy=1 for 20 cycles with incrementing payload -> in-order output, pointers wrap >=4 times, cnt stays 1, no drops.
REQ-036 drdy=0, 300 writes -> drop_cnt=255 (saturated), ovf=1; then rst=0 one cycle -> all outputs zero, next write appears after 1 cycle.
REQ-037 din=0x0005 (valid bit clear) with FIFO empty -> no state change; dvalid=0, cnt=0.
